// File: rtl/ir_pkg.sv
// Shared instruction-word layout and opcode map for the instruction register and its decoder.
package ir_pkg;

    localparam int INSTR_W = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_LDI  = 4'hA,
        OP_JMP  = 4'hB,
        OP_BEQ  = 4'hC,
        OP_BNE  = 4'hD,
        OP_ILL  = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    function automatic logic [INSTR_W-1:0] sext8(input logic [7:0] b);
        return {{(INSTR_W-8){b[7]}}, b};
    endfunction

endpackage

// File: rtl/ir_decode.sv
// Combinational field slicing, sign extension and instruction-class flags for one instruction word.
module ir_decode
    import ir_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [3:0]         rd,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic [7:0]         imm8,
    output logic [INSTR_W-1:0] simm16,
    output logic               is_alu,
    output logic               is_mem,
    output logic               is_load,
    output logic               is_store,
    output logic               is_imm,
    output logic               is_branch,
    output logic               is_halt,
    output logic               is_illegal
);

    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign rs1    = instr[RS1_MSB:RS1_LSB];
    assign rs2    = instr[RS2_MSB:RS2_LSB];
    assign imm8   = instr[IMM_MSB:IMM_LSB];
    assign simm16 = sext8(instr[IMM_MSB:IMM_LSB]);

    // Exactly one class per opcode; NOP leaves every flag low.
    always_comb begin
        is_alu     = 1'b0;
        is_mem     = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_imm     = 1'b0;
        is_branch  = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode_e'(instr[OPC_MSB:OPC_LSB]))
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SHL, OP_SHR:  is_alu = 1'b1;
            OP_LD: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
            end
            OP_ST: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OP_LDI:                  is_imm = 1'b1;
            OP_JMP, OP_BEQ, OP_BNE:  is_branch = 1'b1;
            OP_ILL:                  is_illegal = 1'b1;
            OP_HALT:                 is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ir.sv
// Instruction register: captures the instruction-memory word every edge and exposes its decoded fields.
module ir
    import ir_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] d_in,
    output logic [INSTR_W-1:0] d_out,
    output logic [3:0]         opcode,
    output logic [3:0]         rd,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic [7:0]         imm8,
    output logic [INSTR_W-1:0] simm16,
    output logic               is_alu,
    output logic               is_mem,
    output logic               is_load,
    output logic               is_store,
    output logic               is_imm,
    output logic               is_branch,
    output logic               is_halt,
    output logic               is_illegal
);

    always_ff @(posedge clk) begin
        if (!rst) d_out <= '0;
        else      d_out <= d_in;
    end

    // Decode from the held word only so d_in activity between edges never reaches the outputs.
    ir_decode u_decode (
        .instr      (d_out),
        .opcode     (opcode),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm8       (imm8),
        .simm16     (simm16),
        .is_alu     (is_alu),
        .is_mem     (is_mem),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_imm     (is_imm),
        .is_branch  (is_branch),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

endmodule

// File: tb/tb_ir.sv
// Directed and randomized checks of the instruction register against a behavioural opcode-map model.
module tb_ir;

    logic        clk;
    logic        rst;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic [3:0]  opcode, rd, rs1, rs2;
    logic [7:0]  imm8;
    logic [15:0] simm16;
    logic        is_alu, is_mem, is_load, is_store, is_imm, is_branch, is_halt, is_illegal;

    int          checks;
    int          failures;
    logic [15:0] exp_q;

    ir dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .d_out      (d_out),
        .opcode     (opcode),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm8       (imm8),
        .simm16     (simm16),
        .is_alu     (is_alu),
        .is_mem     (is_mem),
        .is_load    (is_load),
        .is_store   (is_store),
        .is_imm     (is_imm),
        .is_branch  (is_branch),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag order: {alu, mem, load, store, imm, branch, halt, illegal}
    function automatic logic [7:0] model_flags(input logic [15:0] w);
        int op;
        op = int'(w >> 12);
        return {op >= 1 && op <= 7, op == 8 || op == 9, op == 8, op == 9,
                op == 10, op >= 11 && op <= 13, op == 15, op == 14};
    endfunction

    function automatic logic [15:0] model_simm(input logic [15:0] w);
        int v;
        v = int'(w % 256);
        if (v >= 128) v = v - 256;
        return 16'(v);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] fl;
        fl = {is_alu, is_mem, is_load, is_store, is_imm, is_branch, is_halt, is_illegal};
        check({tag, ".d_out"},  d_out, exp_q);
        check({tag, ".opcode"}, 16'(opcode), exp_q / 4096);
        check({tag, ".rd"},     16'(rd),     (exp_q / 256) % 16);
        check({tag, ".rs1"},    16'(rs1),    (exp_q / 16) % 16);
        check({tag, ".rs2"},    16'(rs2),    exp_q % 16);
        check({tag, ".imm8"},   16'(imm8),   exp_q % 256);
        check({tag, ".simm16"}, simm16,      model_simm(exp_q));
        check({tag, ".flags"},  16'(fl),     16'(model_flags(exp_q)));
    endtask

    task automatic step(input logic rst_v, input logic [15:0] din_v);
        @(negedge clk);
        rst  = rst_v;
        d_in = din_v;
        @(posedge clk);
        exp_q = rst_v ? din_v : 16'h0000;
        #1;
    endtask

    initial begin
        logic [15:0] w;
        logic        r;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        d_in     = 16'hFFFF;
        exp_q    = 16'h0000;

        step(1'b0, 16'hFFFF);
        step(1'b0, 16'hFFFF);
        check_all("reset");
        check("reset.d_out_const", d_out, 16'h0000);

        step(1'b1, 16'h00B1);
        check_all("release");
        check("release.rs1_const", 16'(rs1), 16'h000B);
        check("release.rs2_const", 16'(rs2), 16'h0001);

        step(1'b1, 16'h1131); check_all("b2b0");
        check("b2b0.alu", 16'(is_alu), 16'h0001);
        step(1'b1, 16'h00B1); check_all("b2b1");
        step(1'b1, 16'h80B1); check_all("b2b2");
        check("b2b2.load", 16'({is_mem, is_load}), 16'h0003);
        step(1'b1, 16'hC0B1); check_all("b2b3");
        check("b2b3.branch", 16'(is_branch), 16'h0001);

        step(1'b1, 16'hA080); check_all("sext_neg");
        check("sext_neg.const", simm16, 16'hFF80);
        check("sext_neg.imm",   16'(is_imm), 16'h0001);
        step(1'b1, 16'hA07F); check_all("sext_pos");
        check("sext_pos.const", simm16, 16'h007F);

        for (int op = 0; op < 16; op++) begin
            step(1'b1, 16'((op << 12) | 16'h005A));
            check_all($sformatf("sweep%0h", op));
            checks++;
            assert ($countones({is_alu, is_mem, is_imm, is_branch, is_halt, is_illegal}) == (op == 0 ? 0 : 1)) else begin
                failures++;
                $error("FAIL sweep%0h.onehot observed=%b expected_classes=%0d", op,
                       {is_alu, is_mem, is_imm, is_branch, is_halt, is_illegal}, (op == 0 ? 0 : 1));
            end
        end
        check("sweep.illegal_last", 16'({is_halt, is_illegal}), 16'h0002);

        step(1'b1, 16'h9123); check_all("mid_cap");
        step(1'b0, 16'h4567); check_all("mid_rst");
        check("mid_rst.const", d_out, 16'h0000);
        step(1'b1, 16'h4567); check_all("mid_resume");

        // Glitch immunity: d_in wiggles between edges must not reach any output.
        step(1'b1, 16'hB3C4);
        #1 d_in = 16'hF00F;
        #1 d_in = 16'h8001;
        #1 check_all("glitch");
        step(1'b1, d_in); check_all("glitch_next");

        for (int i = 0; i < 300; i++) begin
            w = 16'($urandom);
            r = ($urandom_range(0, 9) != 0);
            step(r, w);
            check_all($sformatf("rand%0d", i));
            if ($urandom_range(0, 3) == 0) begin
                #1 d_in = 16'($urandom);
                #1 check_all($sformatf("rand%0d.glitch", i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
